// File: rtl/stream_fifo_wm.sv
// Ready/valid stream FIFO with arbitrary depth, usage count, runtime watermarks
// and a clearable peak-occupancy register.
module stream_fifo_wm #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_WIDTH-1:0]  usage_o,
  input  logic [CNT_WIDTH-1:0]  afull_thresh_i,
  input  logic [CNT_WIDTH-1:0]  aempty_thresh_i,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_WIDTH-1:0]  peak_o,
  input  logic                  peak_clr_i
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr, rptr;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next, peak, peak_next;
  logic                  empty, bypass, push, pop, push_store, pop_store;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  // Fall-through only applies while storage is empty; otherwise read from memory.
  assign empty   = (cnt == '0);
  assign bypass  = FALL_THROUGH && empty;
  assign ready_o = (cnt != FULL_CNT);
  assign valid_o = bypass ? valid_i : !empty;
  assign data_o  = bypass ? data_i : mem[rptr];

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  // A bypassed transfer never touches storage; flush discards both sides.
  assign push_store = push && !(bypass && pop) && !flush_i;
  assign pop_store  = pop && !bypass && !flush_i;

  assign usage_o        = cnt;
  assign peak_o         = peak;
  assign almost_full_o  = (cnt >= afull_thresh_i);
  assign almost_empty_o = (cnt <= aempty_thresh_i);

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  always_comb begin
    cnt_next = cnt;
    if (flush_i) begin
      cnt_next = '0;
    end else if (push_store && !pop_store) begin
      cnt_next = cnt + ONE_CNT;
    end else if (!push_store && pop_store) begin
      cnt_next = cnt - ONE_CNT;
    end
  end

  always_comb begin
    peak_next = peak;
    if (peak_clr_i) begin
      peak_next = cnt_next;
    end else if (cnt_next > peak) begin
      peak_next = cnt_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      peak <= '0;
    end else begin
      cnt  <= cnt_next;
      peak <= peak_next;
      if (flush_i) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_store) wptr <= next_ptr(wptr);
        if (pop_store)  rptr <= next_ptr(rptr);
      end
    end
  end

  // Payload storage carries no reset; contents are only observed while valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push_store) mem[wptr] <= data_i;
  end

endmodule

// File: tb/tb_stream_fifo_wm.sv
// Self-checking bench for stream_fifo_wm: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_stream_fifo_wm;

  localparam int DW = 8;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          flush, testmode, valid_in, ready_in, peak_clr;
  logic [DW-1:0] data_in;
  logic [CW-1:0] afull, aempty;
  logic          ready_out, valid_out, af_out, ae_out;
  logic [DW-1:0] data_out;
  logic [CW-1:0] usage_out, peak_out;

  logic          ft_flush, ft_valid_in, ft_ready_in, ft_peak_clr;
  logic [DW-1:0] ft_data_in;
  logic [CW-1:0] ft_afull, ft_aempty;
  logic          ft_ready_out, ft_valid_out, ft_af_out, ft_ae_out;
  logic [DW-1:0] ft_data_out;
  logic [CW-1:0] ft_usage_out, ft_peak_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stream_fifo_wm #(.DATA_WIDTH(DW), .DEPTH(D), .FALL_THROUGH(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
    .data_i(data_in), .valid_i(valid_in), .ready_o(ready_out),
    .data_o(data_out), .valid_o(valid_out), .ready_i(ready_in),
    .usage_o(usage_out), .afull_thresh_i(afull), .aempty_thresh_i(aempty),
    .almost_full_o(af_out), .almost_empty_o(ae_out),
    .peak_o(peak_out), .peak_clr_i(peak_clr)
  );

  stream_fifo_wm #(.DATA_WIDTH(DW), .DEPTH(D), .FALL_THROUGH(1'b1)) dut_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(ft_flush), .testmode_i(testmode),
    .data_i(ft_data_in), .valid_i(ft_valid_in), .ready_o(ft_ready_out),
    .data_o(ft_data_out), .valid_o(ft_valid_out), .ready_i(ft_ready_in),
    .usage_o(ft_usage_out), .afull_thresh_i(ft_afull), .aempty_thresh_i(ft_aempty),
    .almost_full_o(ft_af_out), .almost_empty_o(ft_ae_out),
    .peak_o(ft_peak_out), .peak_clr_i(ft_peak_clr)
  );

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          flush;
    logic          clr;
    logic          exp_ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_usage;
    logic          exp_af;
    logic          exp_ae;
    int            exp_peak;
  } vec_t;

  vec_t tbl[12];

  logic [DW-1:0] model_q[$];
  int            model_peak;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    valid_in = v.valid;
    data_in  = v.data;
    ready_in = v.ready;
    flush    = v.flush;
    peak_clr = v.clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    valid_in = 1'b0; ready_in = 1'b0; flush = 1'b0; peak_clr = 1'b0; data_in = '0;
  endtask

  task automatic pulseReset();
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic checkState(input string tag, input int usage, input logic valid, input int peak);
    checkOutput({tag, "_usage"}, 32'(usage_out), 32'(usage));
    checkOutput({tag, "_valid"}, 32'(valid_out), 32'(valid));
    checkOutput({tag, "_peak"}, 32'(peak_out), 32'(peak));
  endtask

  initial begin
    testmode = 1'b0;
    setIdle();
    afull = '0; aempty = CW'(1);
    ft_flush = 1'b0; ft_valid_in = 1'b0; ft_ready_in = 1'b0; ft_peak_clr = 1'b0;
    ft_data_in = '0; ft_afull = CW'(3); ft_aempty = '0;

    // Reset values, including afull threshold of zero forcing almost_full
    #2;
    checkState("rst", 0, 1'b0, 0);
    checkOutput("rst_ready", 32'(ready_out), 32'd1);
    checkOutput("rst_ae", 32'(ae_out), 32'd1);
    checkOutput("rst_af_thr0", 32'(af_out), 32'd1);
    checkOutput("rst_ft_valid", 32'(ft_valid_out), 32'd0);
    afull = CW'(4);
    #10 rst_n = 1'b1;
    tick();

    // Directed table: fill with consumer stalled, then drain, then peak clear
    tbl[0]  = '{1, 8'h10, 0, 0, 0, 1, 1, 8'h10, 1, 0, 1, 1};
    tbl[1]  = '{1, 8'h11, 0, 0, 0, 1, 1, 8'h10, 2, 0, 0, 2};
    tbl[2]  = '{1, 8'h12, 0, 0, 0, 1, 1, 8'h10, 3, 0, 0, 3};
    tbl[3]  = '{1, 8'h13, 0, 0, 0, 1, 1, 8'h10, 4, 1, 0, 4};
    tbl[4]  = '{1, 8'h14, 0, 0, 0, 0, 1, 8'h10, 5, 1, 0, 5};
    tbl[5]  = '{1, 8'h99, 1, 0, 0, 1, 1, 8'h11, 4, 1, 0, 5};
    tbl[6]  = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h12, 3, 0, 0, 5};
    tbl[7]  = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h13, 2, 0, 0, 5};
    tbl[8]  = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h14, 1, 0, 1, 5};
    tbl[9]  = '{0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 5};
    tbl[10] = '{1, 8'hAA, 1, 0, 0, 1, 1, 8'hAA, 1, 0, 1, 5};
    tbl[11] = '{0, 8'h00, 0, 0, 1, 1, 1, 8'hAA, 1, 0, 1, 1};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i]);
      tick();
      checkOutput($sformatf("tbl%0d_ready", i), 32'(ready_out), 32'(tbl[i].exp_ready));
      checkOutput($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        checkOutput($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].exp_data));
      checkOutput($sformatf("tbl%0d_usage", i), 32'(usage_out), 32'(tbl[i].exp_usage));
      checkOutput($sformatf("tbl%0d_af", i), 32'(af_out), 32'(tbl[i].exp_af));
      checkOutput($sformatf("tbl%0d_ae", i), 32'(ae_out), 32'(tbl[i].exp_ae));
      checkOutput($sformatf("tbl%0d_peak", i), 32'(peak_out), 32'(tbl[i].exp_peak));
    end
    setIdle();

    // Flush at usage 3 keeps peak; a following clear drops it to zero
    valid_in = 1'b1;
    data_in = 8'hB1; tick();
    data_in = 8'hB2; tick();
    checkState("preflush", 3, 1'b1, 3);
    data_in = 8'hB3; ready_in = 1'b1; flush = 1'b1;
    tick();
    setIdle();
    checkState("flush", 0, 1'b0, 3);
    checkOutput("flush_ready", 32'(ready_out), 32'd1);
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    checkState("clr", 0, 1'b0, 0);

    // Threshold boundaries at full, and pop at full re-opening ready
    valid_in = 1'b1;
    for (int i = 0; i < D + 1; i++) begin
      data_in = DW'(8'h40 + i);
      tick();
    end
    checkOutput("full_usage", 32'(usage_out), 32'(D));
    checkOutput("full_ready", 32'(ready_out), 32'd0);
    checkOutput("full_data", 32'(data_out), 32'h40);
    afull = CW'(5);  #1 checkOutput("af_eq_depth", 32'(af_out), 32'd1);
    afull = CW'(7);  #1 checkOutput("af_over_depth", 32'(af_out), 32'd0);
    aempty = CW'(5); #1 checkOutput("ae_eq_usage", 32'(ae_out), 32'd1);
    aempty = CW'(4); #1 checkOutput("ae_below_usage", 32'(ae_out), 32'd0);
    ready_in = 1'b1;
    tick();
    setIdle();
    checkOutput("popfull_usage", 32'(usage_out), 32'd4);
    checkOutput("popfull_ready", 32'(ready_out), 32'd1);
    checkOutput("popfull_data", 32'(data_out), 32'h41);

    // Asynchronous reset with data stored, checked before the next clock edge
    #3 rst_n = 1'b0;
    #1;
    checkState("async_rst", 0, 1'b0, 0);
    checkOutput("async_rst_ready", 32'(ready_out), 32'd1);
    #2 rst_n = 1'b1;
    tick();

    // Fall-through: bypass when empty, normal storage otherwise
    ft_valid_in = 1'b1; ft_ready_in = 1'b1; ft_data_in = 8'hAB;
    #1;
    checkOutput("ft_bypass_valid", 32'(ft_valid_out), 32'd1);
    checkOutput("ft_bypass_data", 32'(ft_data_out), 32'hAB);
    tick();
    checkOutput("ft_bypass_usage", 32'(ft_usage_out), 32'd0);
    checkOutput("ft_bypass_peak", 32'(ft_peak_out), 32'd0);
    ft_ready_in = 1'b0; ft_data_in = 8'hCD;
    tick();
    ft_valid_in = 1'b0; ft_data_in = 8'h55;
    #1;
    checkOutput("ft_store_usage", 32'(ft_usage_out), 32'd1);
    checkOutput("ft_store_data", 32'(ft_data_out), 32'hCD);
    checkOutput("ft_store_peak", 32'(ft_peak_out), 32'd1);
    ft_ready_in = 1'b1;
    tick();
    ft_ready_in = 1'b0;
    checkOutput("ft_drain_usage", 32'(ft_usage_out), 32'd0);
    checkOutput("ft_drain_valid", 32'(ft_valid_out), 32'd0);

    // Randomized traffic against a queue model
    pulseReset();
    model_q.delete();
    model_peak = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic m_ready, m_valid, m_push, m_pop;
      int   sz;
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = (cyc % 40 < 12) ? 1'b0 : ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 59) == 0);
      peak_clr = ($urandom_range(0, 29) == 0);
      data_in  = DW'($urandom);
      afull    = CW'($urandom_range(0, 7));
      aempty   = CW'($urandom_range(0, 7));
      #1;
      sz      = model_q.size();
      m_ready = (sz != D);
      m_valid = (sz != 0);
      checkOutput("rnd_ready", 32'(ready_out), 32'(m_ready));
      checkOutput("rnd_valid", 32'(valid_out), 32'(m_valid));
      if (m_valid) checkOutput("rnd_data", 32'(data_out), 32'(model_q[0]));
      checkOutput("rnd_usage", 32'(usage_out), 32'(sz));
      checkOutput("rnd_af", 32'(af_out), 32'(sz >= int'(afull)));
      checkOutput("rnd_ae", 32'(ae_out), 32'(sz <= int'(aempty)));
      checkOutput("rnd_peak", 32'(peak_out), 32'(model_peak));
      m_push = valid_in && m_ready;
      m_pop  = m_valid && ready_in;
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_pop) void'(model_q.pop_front());
        if (m_push) model_q.push_back(data_in);
      end
      if (peak_clr) model_peak = model_q.size();
      else if (model_q.size() > model_peak) model_peak = model_q.size();
      tick();
    end
    setIdle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
